// File: rtl/mem_stage.sv
// MEM stage: data memory with 2-cycle loads, single-cycle stores, branch resolve.
// Ports: clock/reset, EX/MEM fields in, stall/pcSrc/branchTarget, MEM/WB out.
module mem_stage #(
  parameter int MEM_WORDS = 128,
  parameter int LOAD_LAT  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  wbIn,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  input  logic [6:0]  branchAddress,
  input  logic [4:0]  rd,
  input  logic        ZF,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        branch,
  input  logic        BNE,
  output logic        stall,
  output logic        pcSrc,
  output logic [6:0]  branchTarget,
  output logic [1:0]  wbControlMemWb,
  output logic [31:0] readDataMemWb,
  output logic [31:0] aluResultMemWb,
  output logic [4:0]  rdMemWb
);

  localparam int AW = $clog2(MEM_WORDS);

  if (LOAD_LAT != 2) begin : g_bad_lat
    $error("mem_stage: only LOAD_LAT=2 is supported");
  end

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_q [MEM_WORDS];

  logic [1:0]  wb_q, wb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;

  logic [AW-1:0] addr;
  logic          is_load;
  logic          we;

  // Byte offset and high address bits do not select a word.
  logic unused_bits;
  assign unused_bits = ^{aluResult[31:AW+2], aluResult[1:0]};

  assign addr    = aluResult[AW+1:2];
  // A write request turns a simultaneous read into a pure store.
  assign is_load = memRead & ~memWrite;
  assign we      = memWrite & (state_q == IDLE);

  assign stall        = ~reset & (state_q == IDLE) & is_load;
  assign pcSrc        = ~reset & ~stall & branch & (ZF ^ BNE);
  assign branchTarget = branchAddress;

  always_comb begin
    state_d = state_q;
    wb_d    = wbIn;
    rdata_d = '0;
    alu_d   = aluResult;
    rd_d    = rd;
    case (state_q)
      IDLE: begin
        if (is_load) begin
          // First load cycle: send a bubble down to WB.
          state_d = LOAD_WAIT;
          wb_d    = '0;
          alu_d   = '0;
          rd_d    = '0;
        end
      end
      LOAD_WAIT: begin
        state_d = IDLE;
        rdata_d = mem_q[addr];
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wb_q    <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      if (we) begin
        mem_q[addr] <= writeData;
      end
    end
  end

  assign wbControlMemWb = wb_q;
  assign readDataMemWb  = rdata_q;
  assign aluResultMemWb = alu_q;
  assign rdMemWb        = rd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus
// randomized traffic against a behavioural pipeline-register model.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  wbIn;
  logic [31:0] aluResult;
  logic [31:0] writeData;
  logic [6:0]  branchAddress;
  logic [4:0]  rd;
  logic        ZF, memRead, memWrite, branch, BNE;
  logic        stall, pcSrc;
  logic [6:0]  branchTarget;
  logic [1:0]  wbControlMemWb;
  logic [31:0] readDataMemWb;
  logic [31:0] aluResultMemWb;
  logic [4:0]  rdMemWb;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] mmem [128];
  bit          m_pend;
  logic [1:0]  e_wb;
  logic [31:0] e_data;
  logic [31:0] e_alu;
  logic [4:0]  e_rd;

  mem_stage dut (
    .clock          (clock),
    .reset          (reset),
    .wbIn           (wbIn),
    .aluResult      (aluResult),
    .writeData      (writeData),
    .branchAddress  (branchAddress),
    .rd             (rd),
    .ZF             (ZF),
    .memRead        (memRead),
    .memWrite       (memWrite),
    .branch         (branch),
    .BNE            (BNE),
    .stall          (stall),
    .pcSrc          (pcSrc),
    .branchTarget   (branchTarget),
    .wbControlMemWb (wbControlMemWb),
    .readDataMemWb  (readDataMemWb),
    .aluResultMemWb (aluResultMemWb),
    .rdMemWb        (rdMemWb)
  );

  always #5 clock = ~clock;

  function automatic int widx(input logic [31:0] a);
    return int'(a[31:2]) % 128;
  endfunction

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < 128; i++) mmem[i] = '0;
      m_pend = 0;
      e_wb = '0; e_data = '0; e_alu = '0; e_rd = '0;
    end else if (m_pend) begin
      e_wb = wbIn; e_data = mmem[widx(aluResult)];
      e_alu = aluResult; e_rd = rd;
      m_pend = 0;
    end else if (memWrite) begin
      mmem[widx(aluResult)] = writeData;
      e_wb = wbIn; e_data = '0; e_alu = aluResult; e_rd = rd;
    end else if (memRead) begin
      e_wb = '0; e_data = '0; e_alu = '0; e_rd = '0;
      m_pend = 1;
    end else begin
      e_wb = wbIn; e_data = '0; e_alu = aluResult; e_rd = rd;
    end
  endtask

  function automatic logic exp_stall();
    return !reset && !m_pend && memRead && !memWrite;
  endfunction

  function automatic logic exp_pcsrc();
    return !reset && !exp_stall() && branch && (ZF != BNE);
  endfunction

  task automatic drive(input logic r, input logic mr, input logic mw,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] wb, input logic [4:0] d);
    reset = r; memRead = mr; memWrite = mw;
    aluResult = a; writeData = wd; wbIn = wb; rd = d;
    branch = 0; ZF = 0; BNE = 0; branchAddress = '0;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 32'h10, 0, 2'b11, 5'd7);
    branch = 1; ZF = 1; #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL rst_stall got=%b exp=0", stall);
    end
    checks++;
    if (pcSrc !== 1'b0) begin
      failures++; $display("FAIL rst_pcsrc got=%b exp=0", pcSrc);
    end
    tick();
    checks++;
    if ({wbControlMemWb, readDataMemWb, aluResultMemWb, rdMemWb} !== '0) begin
      failures++;
      $display("FAIL rst_out got=%h/%h/%h/%h exp=0", wbControlMemWb,
               readDataMemWb, aluResultMemWb, rdMemWb);
    end
  endtask

  task automatic test_store_load();
    drive(0, 0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 5'd3);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL st_stall got=%b exp=0", stall);
    end
    tick();
    checks++;
    if (readDataMemWb !== 32'h0 || rdMemWb !== 5'd3) begin
      failures++;
      $display("FAIL st_out got=%h/%h exp=0/3", readDataMemWb, rdMemWb);
    end
    drive(0, 1, 0, 32'h10, 0, 2'b11, 5'd5);
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL ld_stall1 got=%b exp=1", stall);
    end
    tick();
    checks++;
    if (wbControlMemWb !== 2'b00 || rdMemWb !== 5'd0) begin
      failures++;
      $display("FAIL ld_bubble got=%b/%h exp=0/0", wbControlMemWb, rdMemWb);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL ld_stall2 got=%b exp=0", stall);
    end
    tick();
    checks++;
    if (readDataMemWb !== 32'hDEADBEEF || rdMemWb !== 5'd5 ||
        wbControlMemWb !== 2'b11 || aluResultMemWb !== 32'h10) begin
      failures++;
      $display("FAIL ld_data got=%h/%h/%b exp=deadbeef/5/11",
               readDataMemWb, rdMemWb, wbControlMemWb);
    end
    // Still presenting the load: back in IDLE, so it stalls again.
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL ld_idle got=%b exp=1", stall);
    end
    drive(0, 0, 0, 32'h0, 0, 2'b00, 5'd0);
    tick();
  endtask

  task automatic test_branch();
    logic [6:0] ba;
    logic [2:0] zb [4];
    logic       ex [4];
    zb[0] = 3'b110; ex[0] = 1;
    zb[1] = 3'b111; ex[1] = 0;
    zb[2] = 3'b101; ex[2] = 1;
    zb[3] = 3'b010; ex[3] = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 32'h0, 0, 2'b00, 5'd0);
      ba = 7'($urandom);
      {branch, ZF, BNE} = zb[i];
      branchAddress = ba;
      #1;
      checks++;
      if (pcSrc !== ex[i] || branchTarget !== ba) begin
        failures++;
        $display("FAIL br_%0d got=%b/%h exp=%b/%h", i, pcSrc,
                 branchTarget, ex[i], ba);
      end
    end
    memRead = 1; branch = 1; ZF = 1; BNE = 0; #1;
    checks++;
    if (pcSrc !== 1'b0) begin
      failures++; $display("FAIL br_stall got=%b exp=0", pcSrc);
    end
    drive(0, 0, 0, 32'h0, 0, 2'b00, 5'd0);
    tick();
  endtask

  task automatic test_wrap();
    drive(0, 0, 1, 32'h204, 32'h55, 2'b00, 5'd0);
    tick();
    drive(0, 1, 0, 32'h004, 0, 2'b10, 5'd9);
    tick();
    tick();
    checks++;
    if (readDataMemWb !== 32'h55) begin
      failures++; $display("FAIL wrap got=%h exp=55", readDataMemWb);
    end
    drive(0, 0, 0, 32'h0, 0, 2'b00, 5'd0);
    tick();
  endtask

  task automatic test_reset_in_load();
    drive(0, 1, 0, 32'h10, 0, 2'b11, 5'd4);
    tick();
    reset = 1; #1;
    tick();
    checks++;
    if ({wbControlMemWb, readDataMemWb, aluResultMemWb, rdMemWb} !== '0) begin
      failures++;
      $display("FAIL rld_out got=%h/%h/%h/%h exp=0", wbControlMemWb,
               readDataMemWb, aluResultMemWb, rdMemWb);
    end
    drive(0, 0, 0, 32'h0, 0, 2'b00, 5'd0);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL rld_stall got=%b exp=0", stall);
    end
    tick();
    drive(0, 1, 0, 32'h10, 0, 2'b11, 5'd4);
    tick();
    tick();
    checks++;
    if (readDataMemWb !== 32'h0 || rdMemWb !== 5'd4) begin
      failures++;
      $display("FAIL rld_mem got=%h/%h exp=0/4", readDataMemWb, rdMemWb);
    end
    drive(0, 0, 0, 32'h0, 0, 2'b00, 5'd0);
    tick();
  endtask

  task automatic test_rw_both();
    drive(0, 1, 1, 32'h40, 32'h1234, 2'b10, 5'd2);
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL rw_stall got=%b exp=0", stall);
    end
    tick();
    checks++;
    if (readDataMemWb !== 32'h0 || aluResultMemWb !== 32'h40) begin
      failures++;
      $display("FAIL rw_out got=%h/%h exp=0/40", readDataMemWb,
               aluResultMemWb);
    end
    drive(0, 1, 0, 32'h40, 0, 2'b01, 5'd1);
    tick();
    tick();
    checks++;
    if (readDataMemWb !== 32'h1234) begin
      failures++; $display("FAIL rw_mem got=%h exp=1234", readDataMemWb);
    end
    drive(0, 0, 0, 32'h0, 0, 2'b00, 5'd0);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        held;
    int          op;
    held = 0;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        op = int'($urandom_range(0, 3));
        a = $urandom;
        a[8:2] = 7'($urandom_range(0, 7));
        drive($urandom_range(0, 39) == 0, op[0], op[1], a, $urandom,
              2'($urandom), 5'($urandom));
        {branch, ZF, BNE} = 3'($urandom);
        branchAddress = 7'($urandom);
        #1;
      end
      checks++;
      if (stall !== exp_stall() || pcSrc !== exp_pcsrc()) begin
        failures++;
        $display("FAIL rnd_comb n=%0d got=%b%b exp=%b%b", n, stall,
                 pcSrc, exp_stall(), exp_pcsrc());
      end
      held = exp_stall();
      tick();
      checks++;
      if (wbControlMemWb !== e_wb || readDataMemWb !== e_data ||
          aluResultMemWb !== e_alu || rdMemWb !== e_rd) begin
        failures++;
        $display("FAIL rnd_out n=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h",
                 n, wbControlMemWb, readDataMemWb, aluResultMemWb,
                 rdMemWb, e_wb, e_data, e_alu, e_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_branch();
    test_wrap();
    test_reset_in_load();
    test_rw_both();
    drive(1, 0, 0, 32'h0, 0, 2'b00, 5'd0);
    tick();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 128, data-memory depth in 32-bit words; word address = aluResult[8:2].
REQ-002 SHALL have parameter LOAD_LAT, default 2, load latency in cycles; only value 2 is supported.
REQ-003 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wbIn  input  2  WB control from EX/MEM; bit1 regWrite, bit0 memToReg.
REQ-006 SHALL have port aluResult  input  32  load/store byte address, or ALU value passed to WB.
REQ-007 SHALL have port writeData  input  32  store data.
REQ-008 SHALL have port branchAddress  input  7  branch target.
REQ-009 SHALL have port rd  input  5  destination register.
REQ-010 SHALL have ports ZF, memRead, memWrite, branch, BNE  input  1 each  EX/MEM flags.
REQ-011 SHALL have port stall  output  1  combinational; upstream holds EX/MEM while high.
REQ-012 SHALL have port pcSrc  output  1  combinational; take branch.
REQ-013 SHALL have port branchTarget  output  7  combinational; equals branchAddress.
REQ-014 SHALL have ports wbControlMemWb (2), readDataMemWb (32), aluResultMemWb (32), rdMemWb (5)  output  registered MEM/WB fields.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, LOAD_WAIT.
REQ-016 IDLE, memRead=1, memWrite=0: stall=1; next state LOAD_WAIT; MEM/WB captures a bubble (all four fields 0).
REQ-017 LOAD_WAIT: stall=0; MEM/WB captures wbIn, mem[aluResult[8:2]], aluResult, rd; next state IDLE.
REQ-018 A load's result SHALL appear on MEM/WB outputs after the second rising edge from its first presented cycle.
REQ-019 IDLE, memWrite=1: mem[aluResult[8:2]] <= writeData at the edge; single cycle; no stall; readDataMemWb captures 0.
REQ-020 memRead and memWrite both 1: treated as a store only; no read, no stall.
REQ-021 IDLE, no memory op: MEM/WB captures wbIn, aluResult, rd; readDataMemWb captures 0.
REQ-022 aluResult[1:0] and aluResult[31:9] SHALL be ignored for addressing; addresses wrap modulo MEM_WORDS.
REQ-023 A load presented the cycle after a store to the same word SHALL return the newly stored data.
REQ-024 pcSrc = branch AND (ZF XOR BNE) when stall=0; pcSrc forced 0 while stall=1.
REQ-025 Memory writes SHALL be suppressed in LOAD_WAIT.

Reset
REQ-026 reset=1 at an edge: state IDLE; wbControlMemWb=0, readDataMemWb=0, aluResultMemWb=0, rdMemWb=0; all memory words cleared to 0.
REQ-027 reset SHALL take priority over every other event at the same edge, including a store or LOAD_WAIT completion.
REQ-028 Reset during LOAD_WAIT abandons the load; no MEM/WB capture; stall is 0 in the cycle after reset.
REQ-029 stall and pcSrc SHALL be 0 while reset is high.

Verification
REQ-030 Store aluResult=0x10, writeData=0xDEADBEEF; next cycle load 0x10, wbIn=2'b11, rd=5 -> stall=1 for exactly one cycle; after 2 edges readDataMemWb=0xDEADBEEF, rdMemWb=5, wbControlMemWb=2'b11.
REQ-031 Load 0x10 held for 2 cycles -> first edge: MEM/WB bubble (wbControlMemWb=0); second edge: valid data; state back to IDLE.
REQ-032 branch=1, ZF=1, BNE=0 -> pcSrc=1; ZF=1, BNE=1 -> pcSrc=0; ZF=0, BNE=1 -> pcSrc=1; branchTarget=branchAddress.
REQ-033 Store 0x55 to address 0x204, then load 0x004 -> 0x55 returned (wrap at 128 words).
REQ-034 Start a load; assert reset in LOAD_WAIT -> all MEM/WB outputs 0, stall=0; a subsequent load of the prior address returns 0.
REQ-035 memRead=1 and memWrite=1 together -> no stall, write performed, readDataMemWb=0.
